// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI target front end.
package qspi_pkg;

   // Receive FSM: waiting for a frame, expecting the high nibble, expecting the low nibble.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } qspi_state_t;

   // Reply byte shifted out when the core has nothing to send at a load point.
   localparam logic [7:0] QSPI_IDLE_TX_BYTE = 8'h00;

   localparam int unsigned QSPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/qspi_sync.sv
// Multi-flop synchronizer chain with a configurable width, depth and reset value.
module qspi_sync #(
   parameter int unsigned      Width    = 1,
   parameter int unsigned      Stages   = 2,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] chain_q [Stages];

   // Shift the asynchronous input through the chain; stage 0 may go metastable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(Stages); i++) begin
            chain_q[i] <= ResetVal;
         end
      end else begin
         chain_q[0] <= d_i;
         for (int i = 1; i < int'(Stages); i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/qspi_slave.sv
// Quad-SPI target front end (mode 0, high nibble first).
// Deserializes nibble pairs into a valid/ready byte stream toward the core and,
// when QSPI_SLAVE_TX_EN is defined, serializes reply bytes onto sdo_o.
// Without QSPI_SLAVE_TX_EN the transmit path is absent and sdo_o/sdo_oe_o/tx_ready_o are 0.
module qspi_slave
   import qspi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = QSPI_SYNC_STAGES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sck_i,
   input  logic       cs_n_i,
   input  logic [3:0] sdi_i,
   output logic [3:0] sdo_o,
   output logic       sdo_oe_o,
   output logic       busy_o,
   output logic [7:0] rx_data_o,
   output logic       rx_first_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       rx_overrun_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o
);

   // ------------------------------------------------------------------
   // Synchronizers and edge detection
   // ------------------------------------------------------------------
   logic       cs_n_s;
   logic       cs_n_q;
   logic       sck_s;
   logic       sck_q;
   logic [3:0] sdi_s;

   qspi_sync #(
      .Width    (1),
      .Stages   (SYNC_STAGES),
      .ResetVal (1'b1)
   ) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cs_n_i),
      .q_o   (cs_n_s)
   );

   // sck and sdi share one chain so data stays aligned with its clock edge.
   qspi_sync #(
      .Width    (5),
      .Stages   (SYNC_STAGES),
      .ResetVal (5'b0)
   ) u_sync_data (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({sck_i, sdi_i}),
      .q_o   ({sck_s, sdi_s})
   );

   // One extra registered copy of each synchronized control for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_q <= 1'b1;
         sck_q  <= 1'b0;
      end else begin
         cs_n_q <= cs_n_s;
         sck_q  <= sck_s;
      end
   end

   logic cs_fall;
   logic cs_rise;
   logic sck_rise;

   assign cs_fall  = cs_n_q & ~cs_n_s;
   assign cs_rise  = ~cs_n_q & cs_n_s;
   assign sck_rise = ~sck_q & sck_s;

   // Registered copy goes active in the same cycle the first reply nibble appears.
   assign busy_o = ~cs_n_q;

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   qspi_state_t state_q, state_d;
   logic [3:0]  hi_q, hi_d;
   logic        byte_done;

   // Next state: cs_n rise always wins and discards any partial byte.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      byte_done = 1'b0;
      if (cs_rise) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // sck edges are ignored here, including the cs_n fall cycle
               if (cs_fall) begin
                  state_d = HI;
               end
            end
            HI: begin
               if (sck_rise) begin
                  hi_d    = sdi_s;
                  state_d = LO;
               end
            end
            LO: begin
               if (sck_rise) begin
                  byte_done = 1'b1;
                  state_d   = HI;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state and high-nibble latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hi_q    <= 4'h0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
      end
   end

   // ------------------------------------------------------------------
   // Receive holding register
   // ------------------------------------------------------------------
   logic       first_q, first_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_first_q, rx_first_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_overrun_q, rx_overrun_d;

   // Load a completed byte if the slot is free (or frees this cycle), else drop it.
   always_comb begin
      first_d      = first_q;
      rx_data_d    = rx_data_q;
      rx_first_d   = rx_first_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = 1'b0;
      if (cs_fall) begin
         first_d = 1'b1;
      end
      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end
      if (byte_done) begin
         first_d = 1'b0;
         if (!rx_valid_q || rx_ready_i) begin
            rx_data_d  = {hi_q, sdi_s};
            rx_first_d = first_q;
            rx_valid_d = 1'b1;
         end else begin
            rx_overrun_d = 1'b1;
         end
      end
   end

   // Holding register state; deliberately untouched by cs_n rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q      <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_first_q   <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         first_q      <= first_d;
         rx_data_q    <= rx_data_d;
         rx_first_q   <= rx_first_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign rx_data_o    = rx_data_q;
   assign rx_first_o   = rx_first_q;
   assign rx_valid_o   = rx_valid_q;
   assign rx_overrun_o = rx_overrun_q;

   // ------------------------------------------------------------------
   // Transmit path
   // ------------------------------------------------------------------
`ifdef QSPI_SLAVE_TX_EN
   logic       sck_fall;
   logic       rose_q, rose_d;
   logic       nib_lo_q, nib_lo_d;
   logic [7:0] tx_q, tx_d;
   logic       tx_ready_q, tx_ready_d;

   assign sck_fall = sck_q & ~sck_s;

   // rose_q marks a fall as belonging to an in-frame rise. After a high-nibble rise
   // the FSM sits in LO (switch to low nibble); after a low-nibble rise it sits in HI
   // (byte boundary, load the next reply byte).
   always_comb begin
      rose_d     = rose_q;
      nib_lo_d   = nib_lo_q;
      tx_d       = tx_q;
      tx_ready_d = 1'b0;
      if (cs_rise || cs_fall) begin
         rose_d = 1'b0;
      end else if (sck_rise && (state_q != IDLE)) begin
         rose_d = 1'b1;
      end else if (sck_fall) begin
         rose_d = 1'b0;
      end
      if (cs_fall || (!cs_rise && sck_fall && rose_q && (state_q == HI))) begin
         tx_ready_d = 1'b1;
         tx_d       = tx_valid_i ? tx_data_i : QSPI_IDLE_TX_BYTE;
         nib_lo_d   = 1'b0;
      end else if (!cs_rise && sck_fall && rose_q && (state_q == LO)) begin
         nib_lo_d = 1'b1;
      end
   end

   // Reply byte, nibble select and load-point strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rose_q     <= 1'b0;
         nib_lo_q   <= 1'b0;
         tx_q       <= 8'h00;
         tx_ready_q <= 1'b0;
      end else begin
         rose_q     <= rose_d;
         nib_lo_q   <= nib_lo_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign sdo_o      = busy_o ? (nib_lo_q ? tx_q[3:0] : tx_q[7:4]) : 4'h0;
   assign sdo_oe_o   = busy_o;
   assign tx_ready_o = tx_ready_q;
`else
   logic unused_tx;

   assign unused_tx  = ^{tx_data_i, tx_valid_i};
   assign sdo_o      = 4'h0;
   assign sdo_oe_o   = 1'b0;
   assign tx_ready_o = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_slave.sv
// Self-checking bench for qspi_slave: directed scenarios plus randomized frames
// checked against a byte-level model of the receive slot and reply stream.
module tb_qspi_slave;

   localparam int unsigned SS = 2;
   localparam int          H  = 8;   // SPI half period in clk cycles
`ifdef QSPI_SLAVE_TX_EN
   localparam bit TX_EN = 1'b1;
`else
   localparam bit TX_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sck_i, cs_n_i, rx_ready_i, tx_valid_i;
   logic [3:0] sdi_i, sdo_o;
   logic       sdo_oe_o, busy_o, rx_first_o, rx_valid_o, rx_overrun_o, tx_ready_o;
   logic [7:0] rx_data_o, tx_data_i;

   int n_vec = 0;
   int n_err = 0;
   int ovr_cnt = 0;
   int txr_cnt = 0;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] fb[$];
   logic [7:0] ftx_d[$];
   bit         ftx_v[$];
   bit         hold_valid;
   logic [8:0] hold_byte;
   int         exp_ovr, exp_txr;

   qspi_slave #(.SYNC_STAGES(SS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sck_i        (sck_i),
      .cs_n_i       (cs_n_i),
      .sdi_i        (sdi_i),
      .sdo_o        (sdo_o),
      .sdo_oe_o     (sdo_oe_o),
      .busy_o       (busy_o),
      .rx_data_o    (rx_data_o),
      .rx_first_o   (rx_first_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (rx_ready_i),
      .rx_overrun_o (rx_overrun_o),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o)
   );

   always #5 clk = ~clk;

   // Observe the core side between edges: accepted bytes, overrun and load strobes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid_o && rx_ready_i) got_q.push_back({rx_first_o, rx_data_o});
         if (rx_overrun_o) ovr_cnt++;
         if (tx_ready_o) txr_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic cs_lo();
      cs_n_i = 1'b0;
      tick(H);
   endtask

   task automatic cs_hi();
      tick(H);
      cs_n_i = 1'b1;
      tick(H);
   endtask

   task automatic nib(input logic [3:0] n);
      sdi_i = n;
      tick(H);
      sck_i = 1'b1;
      tick(H);
      sck_i = 1'b0;
   endtask

   // Drives one frame from fb/ftx and updates the model; checks sdo per nibble.
   task automatic run_frame(input int nnib, input bit ready);
      logic [7:0] tb;
      logic [3:0] expn;
      int b;
      rx_ready_i = ready;
      tx_valid_i = ftx_v[0];
      tx_data_i  = ftx_d[0];
      tick(1);
      cs_n_i = 1'b0;
      tick(H);
      for (int k = 0; k < nnib; k++) begin
         b    = k / 2;
         tb   = ftx_v[b] ? ftx_d[b] : 8'h00;
         expn = TX_EN ? ((k % 2 == 0) ? tb[7:4] : tb[3:0]) : 4'h0;
         sdi_i = (k % 2 == 0) ? fb[b][7:4] : fb[b][3:0];
         tick(H);
         n_vec++;
         if (sdo_o !== expn) begin
            n_err++;
            $display("FAIL rand_sdo nib %0d: got %h want %h", k, sdo_o, expn);
         end
         n_vec++;
         if (sdo_oe_o !== TX_EN || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rand_oe_busy: got %b%b want %b1", sdo_oe_o, busy_o, TX_EN);
         end
         sck_i = 1'b1;
         tick(H);
         sck_i = 1'b0;
         if (k % 2 == 1) begin
            if (ready) exp_q.push_back({(b == 0), fb[b]});
            else if (!hold_valid) begin
               hold_valid = 1'b1;
               hold_byte  = {(b == 0), fb[b]};
            end else exp_ovr++;
            tx_valid_i = ftx_v[b+1];
            tx_data_i  = ftx_d[b+1];
         end
      end
      tick(H);
      cs_n_i = 1'b1;
      tick(H);
      if (TX_EN) exp_txr += nnib / 2 + 1;
      n_vec++;
      if (sdo_oe_o !== 1'b0 || sdo_o !== 4'h0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL rand_idle_out: got oe=%b sdo=%h busy=%b want 0 0 0",
                  sdo_oe_o, sdo_o, busy_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sck_i = 1'b0; cs_n_i = 1'b1; sdi_i = 4'h0;
      rx_ready_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      n_vec++; if (sdo_o !== 4'h0) begin n_err++; $display("FAIL reset_sdo: got %h want 0", sdo_o); end
      n_vec++; if (sdo_oe_o !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", sdo_oe_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_vec++; if (rx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
      n_vec++; if (rx_first_o !== 1'b0) begin n_err++; $display("FAIL reset_first: got %b want 0", rx_first_o); end
      n_vec++; if (rx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
      n_vec++; if (rx_overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", rx_overrun_o); end
      n_vec++; if (tx_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_txr: got %b want 0", tx_ready_o); end
   endtask

   task automatic test_rx_basic();
      int o0 = ovr_cnt;
      got_q.delete();
      rx_ready_i = 1'b1;
      cs_lo();
      nib(4'h3);
      sdi_i = 4'hC;
      tick(H);
      sck_i = 1'b1;
      tick(SS);
      n_vec++; if (rx_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", rx_valid_o); end
      tick(1);
      n_vec++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C || rx_first_o !== 1'b1) begin
         n_err++;
         $display("FAIL basic_load: got v=%b d=%h f=%b want 1 3c 1", rx_valid_o, rx_data_o, rx_first_o);
      end
      tick(H - SS - 1);
      sck_i = 1'b0;
      cs_hi();
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 9'h13C) begin
         n_err++;
         $display("FAIL basic_accept: got n=%0d first=%h want 1 13c", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h0);
      end
      n_vec++; if (ovr_cnt != o0) begin n_err++; $display("FAIL basic_ovr: got %0d want 0", ovr_cnt - o0); end
   endtask

   task automatic test_overrun();
      int o0 = ovr_cnt;
      rx_ready_i = 1'b0;
      cs_lo();
      nib(4'hA); nib(4'h5); nib(4'h5); nib(4'hA);
      cs_hi();
      n_vec++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5 || rx_first_o !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_hold: got v=%b d=%h f=%b want 1 a5 1", rx_valid_o, rx_data_o, rx_first_o);
      end
      n_vec++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - o0); end
      got_q.delete();
      rx_ready_i = 1'b1;
      tick(3);
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 9'h1A5 || rx_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_drain: got n=%0d v=%b want 1 0", got_q.size(), rx_valid_o);
      end
   endtask

   task automatic test_tx();
      logic [3:0] e [4];
      int t0 = txr_cnt;
      e[0] = TX_EN ? 4'h9 : 4'h0; e[1] = TX_EN ? 4'h6 : 4'h0;
      e[2] = 4'h0; e[3] = 4'h0;
      rx_ready_i = 1'b1;
      tx_valid_i = 1'b1;
      tx_data_i  = 8'h96;
      tick(1);
      cs_n_i = 1'b0;
      tick(H);
      n_vec++; if (txr_cnt - t0 != (TX_EN ? 1 : 0)) begin n_err++; $display("FAIL tx_ready_csfall: got %0d want %0d", txr_cnt - t0, TX_EN ? 1 : 0); end
      n_vec++; if (sdo_oe_o !== TX_EN) begin n_err++; $display("FAIL tx_oe_active: got %b want %b", sdo_oe_o, TX_EN); end
      for (int k = 0; k < 4; k++) begin
         sdi_i = 4'(k);
         n_vec++;
         if (sdo_o !== e[k]) begin n_err++; $display("FAIL tx_sdo nib %0d: got %h want %h", k, sdo_o, e[k]); end
         sck_i = 1'b1;
         tick(H);
         sck_i = 1'b0;
         if (k == 0) tx_valid_i = 1'b0;
         tick(H);
      end
      cs_n_i = 1'b1;
      tick(H);
      n_vec++;
      if (sdo_oe_o !== 1'b0 || sdo_o !== 4'h0) begin
         n_err++;
         $display("FAIL tx_oe_idle: got oe=%b sdo=%h want 0 0", sdo_oe_o, sdo_o);
      end
      n_vec++; if (txr_cnt - t0 != (TX_EN ? 3 : 0)) begin n_err++; $display("FAIL tx_ready_total: got %0d want %0d", txr_cnt - t0, TX_EN ? 3 : 0); end
   endtask

   task automatic test_abort();
      got_q.delete();
      rx_ready_i = 1'b1;
      cs_lo();
      nib(4'hF);
      cs_hi();
      cs_lo();
      nib(4'h1); nib(4'h2);
      cs_hi();
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 9'h112) begin
         n_err++;
         $display("FAIL abort_next: got n=%0d b=%h want 1 112", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h0);
      end
   endtask

   task automatic test_back_to_back();
      int o0 = ovr_cnt;
      got_q.delete();
      rx_ready_i = 1'b0;
      cs_lo();
      nib(4'h4); nib(4'h1); nib(4'hB);
      sdi_i = 4'hD;
      tick(H);
      sck_i = 1'b1;
      tick(SS);
      rx_ready_i = 1'b1;
      tick(1);
      rx_ready_i = 1'b0;
      n_vec++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hBD || rx_first_o !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_load: got v=%b d=%h f=%b want 1 bd 0", rx_valid_o, rx_data_o, rx_first_o);
      end
      tick(H - SS - 1);
      sck_i = 1'b0;
      cs_hi();
      rx_ready_i = 1'b1;
      tick(3);
      n_vec++;
      if (got_q.size() != 2 || got_q[0] !== 9'h141 || got_q[1] !== 9'h0BD) begin
         n_err++;
         $display("FAIL b2b_order: got n=%0d want 2 (141, 0bd)", got_q.size());
      end
      n_vec++; if (ovr_cnt != o0) begin n_err++; $display("FAIL b2b_ovr: got %0d want 0", ovr_cnt - o0); end
   endtask

   task automatic test_reset_mid();
      int o0;
      rx_ready_i = 1'b0;
      cs_lo();
      nib(4'h5); nib(4'h5); nib(4'h9);
      sdi_i = 4'h3;
      tick(H);
      sck_i = 1'b1;
      tick(1);
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || rx_first_o !== 1'b0 ||
          rx_overrun_o !== 1'b0 || busy_o !== 1'b0 || sdo_o !== 4'h0 ||
          sdo_oe_o !== 1'b0 || tx_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b d=%h f=%b o=%b busy=%b sdo=%h oe=%b txr=%b want all 0",
                  rx_valid_o, rx_data_o, rx_first_o, rx_overrun_o, busy_o, sdo_o, sdo_oe_o,
                  tx_ready_o);
      end
      sck_i  = 1'b0;
      cs_n_i = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(H);
      got_q.delete();
      o0 = ovr_cnt;
      rx_ready_i = 1'b1;
      cs_lo();
      nib(4'h7); nib(4'hE);
      cs_hi();
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 9'h17E || ovr_cnt != o0) begin
         n_err++;
         $display("FAIL rst_recover: got n=%0d b=%h ovr=%0d want 1 17e 0", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h0, ovr_cnt - o0);
      end
   endtask

   task automatic test_random();
      int nb, o0, t0;
      bit rdy;
      for (int f = 0; f < 20; f++) begin
         nb  = $urandom_range(1, 4);
         rdy = 1'($urandom_range(0, 1));
         fb.delete(); ftx_d.delete(); ftx_v.delete();
         for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
         for (int i = 0; i <= nb; i++) begin
            ftx_v.push_back(1'($urandom_range(0, 1)));
            ftx_d.push_back(8'($urandom));
         end
         got_q.delete(); exp_q.delete();
         hold_valid = 1'b0; exp_ovr = 0; exp_txr = 0;
         o0 = ovr_cnt; t0 = txr_cnt;
         run_frame(nb * 2, rdy);
         rx_ready_i = 1'b1;
         tick(3);
         if (hold_valid) exp_q.push_back(hold_byte);
         n_vec++;
         if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count frame %0d: got %0d want %0d", f, got_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               n_vec++;
               if (got_q[i] !== exp_q[i]) begin
                  n_err++;
                  $display("FAIL rand_byte frame %0d idx %0d: got %h want %h", f, i, got_q[i], exp_q[i]);
               end
            end
         end
         n_vec++; if (ovr_cnt - o0 != exp_ovr) begin n_err++; $display("FAIL rand_ovr frame %0d: got %0d want %0d", f, ovr_cnt - o0, exp_ovr); end
         n_vec++; if (txr_cnt - t0 != exp_txr) begin n_err++; $display("FAIL rand_txr frame %0d: got %0d want %0d", f, txr_cnt - t0, exp_txr); end
      end
   endtask

   initial begin
      test_reset();
      test_rx_basic();
      test_overrun();
      test_tx();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qspi_slave.md
# qspi_slave

Quad-SPI target front end for the chess engine. Sits between the pins (`sck`, `cs_n`, `sdi[3:0]` in, `sdo[3:0]` out) and the engine core. It synchronizes the asynchronous SPI signals into `clk`, deserializes nibble pairs into bytes on a valid/ready stream toward the core, and serializes core reply bytes back onto `sdo`. SPI mode 0 (sample on `sck` rise, drive on `sck` fall), high nibble first.

## Interface
- `SYNC_STAGES`, default 2, flops per synchronizer chain (≥2)
- `clk` in 1, system clock
- `rst_n` in 1, asynchronous active-low reset
- `sck_i` in 1, SPI clock, asynchronous to `clk`
- `cs_n_i` in 1, SPI chip select, active low, asynchronous
- `sdi_i` in 4, SPI data in, asynchronous
- `sdo_o` out 4, SPI data out
- `sdo_oe_o` out 1, output enable for `sdo_o`
- `busy_o` out 1, synchronized `cs` active
- `rx_data_o` out 8, received byte
- `rx_first_o` out 1, `rx_data_o` is the first byte of its frame
- `rx_valid_o` out 1, `rx_data_o` held valid
- `rx_ready_i` in 1, core accepts byte
- `rx_overrun_o` out 1, one-cycle pulse when a completed byte is dropped
- `tx_data_i` in 8, reply byte
- `tx_valid_i` in 1, `tx_data_i` valid
- `tx_ready_o` out 1, one-cycle pulse at a byte load point

## Operation
- `sck_i`, `cs_n_i`, `sdi_i` each pass through a `SYNC_STAGES` chain. `cs_n` resets to 1; the others reset to 0. Edges are detected by comparing the chain output with one further registered copy.
- Receive FSM states:
  - IDLE → HI on synchronized `cs_n` fall. The `first` flag is set.
  - HI → LO on `sck` rise: latch the high nibble.
  - LO → HI on `sck` rise: the byte is {hi, sdi}.
  - Any state → IDLE on `cs_n` rise. A partial byte is discarded.
- `sck` edges are ignored in IDLE and in the same cycle as the `cs_n` fall detection.
- Byte completion:
  - Holding register empty, or `rx_ready_i` high this cycle: load `rx_data_o`, set `rx_valid_o`, set `rx_first_o` = `first`, clear `first`.
  - Otherwise: drop the byte, pulse `rx_overrun_o`, keep the held byte, clear `first`.
- `rx_valid_o` clears on `rx_valid_o && rx_ready_i`, unless a new byte loads in the same cycle. It survives `cs_n` rise.
- Transmit load points are the `cs_n` fall and each `sck` fall following a low-nibble rise.
  - At each load point `tx_ready_o` pulses for one cycle.
  - If `tx_valid_i` is high, `tx_data_i` loads into the tx register; otherwise 8'h00 loads.
  - `sdo_o` = tx[7:4] after the load, then tx[3:0] after the `sck` fall following the high-nibble rise.
- `sdo_oe_o` = `busy_o`. `sdo_o` forces to 0 when not busy.

## Timing
- Reset values: `sdo_o`=0, `sdo_oe_o`=0, `busy_o`=0, `rx_data_o`=0, `rx_first_o`=0, `rx_valid_o`=0, `rx_overrun_o`=0, `tx_ready_o`=0. FSM returns to IDLE and tx register clears. Reset mid-byte discards everything immediately (asynchronous).
- `rx_valid_o` rises SYNC_STAGES+1 `clk` edges after the `sck` rise carrying the low nibble.
- `sdo_o` updates SYNC_STAGES+1 `clk` edges after the `sck` fall or `cs_n` fall. `tx_ready_o` pulses in that same update cycle.
- Host requirement: `sck` high and low phases each last ≥ SYNC_STAGES+3 `clk` periods. `cs_n` fall precedes the first `sck` rise by the same amount.

## Configuration
- `QSPI_SLAVE_TX_EN` defined: the full transmit path as above.
- Undefined: no tx register or logic. `sdo_o`=0, `sdo_oe_o`=0, `tx_ready_o`=0 permanently, and `tx_data_i`/`tx_valid_i` are ignored. Receive is unchanged.

## Structure
- Package `qspi_pkg`:
  - FSM enum `qspi_state_t` {IDLE, HI, LO}
  - `QSPI_IDLE_TX_BYTE` = 8'h00
  - `QSPI_SYNC_STAGES_DEFAULT` = 2
- Sub-module `qspi_sync`: parameterized width, stage count and reset value. Instantiated for `cs_n` (reset 1) and for {`sck`, `sdi`} (reset 0).

## Test plan
- Frame with nibbles 3, C and `rx_ready_i`=1 → one `rx_valid_o` with `rx_data_o`=8'h3C, `rx_first_o`=1.
- Frame A5, 5A with `rx_ready_i`=0 → `rx_data_o` holds 8'hA5 (`first`=1); exactly one `rx_overrun_o` pulse at the second byte.
- `tx_valid_i`=1, `tx_data_i`=8'h96 before `cs_n` fall, then low for the second byte → `tx_ready_o` pulse at `cs_n` fall; `sdo_o` shows 9, 6, then 0, 0; `sdo_oe_o`=1 only while `cs` is active.
- `cs_n` rises after one nibble, then a new frame sends 8'h12 → no byte from the aborted frame; 8'h12 arrives with `rx_first_o`=1.
- `rx_ready_i` high in the same cycle the next byte completes → new byte loads, no overrun.
- `rst_n` low mid-byte → all outputs at reset values within the same cycle. The next frame receives 8'h7E correctly.
